function_scan_ctrl: RTL and testbench
=====================================

Name: function_scan_ctrl

Overview:
- Sequencer that exhaustively drives the select/data inputs (A..E) of a combinational decoder/mux function block and captures its output Y for every input combination.
- Produces the full truth table and compares it against an expected table. Reports pass/fail, mismatch count and first failing index.
- Sits between a test/control host and the combinational function datapath; the datapath itself is unchanged.

Parameters:
- N_IN, 5, number of function inputs; scan length is 2^N_IN vectors.
- SETTLE, 1, cycles each vector is held before Y is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  level; sampled only in IDLE; begins a scan.
- abort  input  1  level; terminates a scan in progress.
- exp_tt  input  2^N_IN  expected truth table; bit i = expected Y for vector i. Must be stable while busy.
- y_in  input  1  function output Y from the datapath.
- vec_out  output  N_IN  registered vector to datapath; MSB drives A, LSB drives the last input.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when a scan completes.
- aborted  output  1  one-cycle pulse when a scan is aborted.
- tt_out  output  2^N_IN  captured truth table; bit i = Y sampled for vector i.
- mismatch_cnt  output  N_IN+1  number of bits where tt_out differs from exp_tt.
- first_fail_idx  output  N_IN  lowest failing vector index.
- first_fail_valid  output  1  at least one mismatch has been recorded.
- pass  output  1  last completed scan had zero mismatches.

Behaviour:
- Reset (rst_n low, effective immediately regardless of clock): state IDLE, and all outputs 0 (vec_out, busy, done, aborted, tt_out, mismatch_cnt, first_fail_idx, first_fail_valid, pass).
- States are IDLE, SCAN, DONE.
- IDLE:
  - abort=1: stay IDLE; abort wins over simultaneous start.
  - Otherwise, start=1 at edge E0:
    - vec_out<=0, busy<=1.
    - tt_out, mismatch_cnt, first_fail_idx and first_fail_valid cleared; pass<=0.
    - Hold counter loaded with SETTLE-1; go to SCAN.
- SCAN:
  - Each vector i is held for exactly SETTLE cycles.
  - At edge E0+SETTLE*(i+1):
    - tt_out[i]<=y_in.
    - If y_in!=exp_tt[i]: mismatch_cnt increments. If first_fail_valid=0: first_fail_idx<=i and first_fail_valid<=1.
  - Then, if i<2^N_IN-1: vec_out<=i+1 and the hold counter reloads.
  - If i=2^N_IN-1 (last vector):
    - Go to DONE; busy<=0, done<=1, vec_out<=0.
    - pass<=1 iff the final mismatch count, including this last sample, is 0.
- Scan latency: done is high in the cycle following edge E0+SETTLE*2^N_IN. For N_IN=5, SETTLE=1 that is 32 edges after E0.
- DONE:
  - Lasts one cycle; done drops and the state returns to IDLE.
  - start is ignored in DONE. Earliest next scan is the edge after returning to IDLE.
- abort=1 at any SCAN edge:
  - No sample is taken at that edge.
  - State goes to IDLE; busy<=0, aborted<=1 for one cycle, vec_out<=0, pass<=0.
  - tt_out, mismatch_cnt and first_fail fields keep their partial values.
- start while busy or in DONE: no effect.
- Results hold until the next accepted start or reset.
- Vector counter does not wrap during a scan. Index 2^N_IN-1 is terminal.
- mismatch_cnt is N_IN+1 bits wide so that 2^N_IN mismatches is representable; it never saturates or wraps.

Test Plan:
- Reset mid-scan: assert rst_n=0 at vector 12 → all outputs 0 asynchronously, before the next clock edge. After release, state is IDLE and start is accepted.
- SETTLE=1, bench y_in = vec_out[0], exp_tt=32'hAAAAAAAA, start pulse → vec_out steps 0..31 one per cycle; done pulses 32 edges after E0; tt_out=32'hAAAAAAAA, mismatch_cnt=0, pass=1, first_fail_valid=0.
- Same stimulus, exp_tt=32'hAAAA8A8B (bits 0, 5 and 13 flipped) → mismatch_cnt=3, first_fail_idx=0, first_fail_valid=1, pass=0, tt_out=32'hAAAAAAAA.
- SETTLE=3, y_in = delayed-by-2-cycles model of any 5-input function, matching exp_tt → each vec_out value held 3 cycles; done 96 edges after E0; pass=1.
- abort=1 while vec_out=10 → busy falls and aborted pulses at that edge; done never asserts; vec_out=0; tt_out[9:0] hold captured values and tt_out[31:10]=0.
- start held high continuously → scans run back-to-back with exactly a DONE cycle plus one IDLE cycle between scans; start toggles during SCAN cause no restart and no counter disturbance.

Source files
------------

// File: rtl/function_scan_ctrl_if.sv
// Host/datapath bundle for the truth-table scan controller.
// The master side is the host plus datapath; the controller is the slave.
interface function_scan_ctrl_if #(
    parameter int N_IN = 5
);
    localparam int TT_W = 2 ** N_IN;

    logic              start;
    logic              abort;
    logic [TT_W-1:0]   exp_tt;
    logic              y_in;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [TT_W-1:0]   tt_out;
    logic [N_IN:0]     mismatch_cnt;
    logic [N_IN-1:0]   first_fail_idx;
    logic              first_fail_valid;
    logic              pass;

    modport master (
        output start, abort, exp_tt, y_in,
        input  vec_out, busy, done, aborted, tt_out, mismatch_cnt,
               first_fail_idx, first_fail_valid, pass
    );

    modport slave (
        input  start, abort, exp_tt, y_in,
        output vec_out, busy, done, aborted, tt_out, mismatch_cnt,
               first_fail_idx, first_fail_valid, pass
    );
endinterface

// File: rtl/function_scan_ctrl.sv
// Exhaustive input sequencer for a combinational function block: walks all
// 2^N_IN vectors, captures Y per vector and grades it against an expected table.
module function_scan_ctrl #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    function_scan_ctrl_if.slave  bus
);
    localparam int              TT_W      = 2 ** N_IN;
    localparam logic [3:0]      HOLD_INIT = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [N_IN-1:0]   vec_q;
    logic [3:0]        hold_q;
    logic              busy_q;
    logic              done_q;
    logic              aborted_q;
    logic [TT_W-1:0]   tt_q;
    logic [N_IN:0]     mcnt_q;
    logic [N_IN-1:0]   ffidx_q;
    logic              ffvalid_q;
    logic              pass_q;

    logic              mismatch_d;
    logic [N_IN:0]     mcnt_d;

    // Grade of the vector currently on the bus; only committed on a sample edge.
    assign mismatch_d = bus.y_in != bus.exp_tt[vec_q];
    assign mcnt_d     = mcnt_q + {{N_IN{1'b0}}, mismatch_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            tt_q      <= '0;
            mcnt_q    <= '0;
            ffidx_q   <= '0;
            ffvalid_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.abort && bus.start) begin
                        state_q   <= SCAN;
                        vec_q     <= '0;
                        hold_q    <= HOLD_INIT;
                        busy_q    <= 1'b1;
                        tt_q      <= '0;
                        mcnt_q    <= '0;
                        ffidx_q   <= '0;
                        ffvalid_q <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        // Partial results are deliberately left visible.
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        vec_q     <= '0;
                        pass_q    <= 1'b0;
                    end else if (hold_q != 4'd0) begin
                        hold_q <= hold_q - 4'd1;
                    end else begin
                        tt_q[vec_q] <= bus.y_in;
                        mcnt_q      <= mcnt_d;
                        if (mismatch_d && !ffvalid_q) begin
                            ffidx_q   <= vec_q;
                            ffvalid_q <= 1'b1;
                        end
                        if (vec_q == LAST_VEC) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            vec_q   <= '0;
                            pass_q  <= (mcnt_d == '0);
                        end else begin
                            vec_q  <= vec_q + 1'b1;
                            hold_q <= HOLD_INIT;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.vec_out          = vec_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.aborted          = aborted_q;
    assign bus.tt_out           = tt_q;
    assign bus.mismatch_cnt     = mcnt_q;
    assign bus.first_fail_idx   = ffidx_q;
    assign bus.first_fail_valid = ffvalid_q;
    assign bus.pass             = pass_q;
endmodule

// File: tb/tb_function_scan_ctrl.sv
// Directed bench: a SETTLE=1 controller driven by y=vec[0] and a SETTLE=3
// controller driven by a two-cycle-delayed 5-input function.
module tb_function_scan_ctrl;
    logic clk;
    logic rst_n;

    int tests;
    int fails;

    function_scan_ctrl_if #(.N_IN(5)) u0 ();
    function_scan_ctrl_if #(.N_IN(5)) u1 ();

    function_scan_ctrl #(.N_IN(5), .SETTLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(u0.slave));
    function_scan_ctrl #(.N_IN(5), .SETTLE(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(u1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic f5(input logic [4:0] v);
        return (v[4] & v[3]) | ((v[2] ^ v[0]) & ~v[1]);
    endfunction

    logic [4:0] d1 = '0;
    logic [4:0] d2 = '0;
    always @(posedge clk) begin
        d1 <= u1.vec_out;
        d2 <= d1;
    end

    assign u0.y_in = u0.vec_out[0];
    assign u1.y_in = f5(d2);

    typedef struct {
        logic [31:0] exp_tt;
        logic [5:0]  mcnt;
        logic [4:0]  ffidx;
        logic        ffvalid;
        logic        pass;
    } scan_vec_t;

    scan_vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs0();
        return {u0.vec_out, u0.busy, u0.done, u0.aborted, u0.tt_out, u0.mismatch_cnt,
                u0.first_fail_idx, u0.first_fail_valid, u0.pass};
    endfunction

    // Starts a scan on u0 from IDLE and runs to done; lat = edges after E0.
    task automatic scan0(input logic [31:0] exp, output int lat, output bit step_ok);
        u0.exp_tt = exp;
        u0.start  = 1'b1;
        tick();
        u0.start  = 1'b0;
        step_ok = (u0.busy === 1'b1) && (u0.vec_out === 5'd0) && (u0.tt_out === 32'h0);
        lat = 0;
        while (u0.done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
            if (u0.done !== 1'b1 && u0.vec_out !== 5'(lat)) step_ok = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        bit          ok;
        logic [31:0] exp1;

        tests = 0;
        fails = 0;
        u0.start = 0; u0.abort = 0; u0.exp_tt = '0;
        u1.start = 0; u1.abort = 0; u1.exp_tt = '0;

        tbl[0] = '{32'hAAAA8A8B, 6'd3,  5'd0,  1'b1, 1'b0};
        tbl[1] = '{32'hAAAAAAAA, 6'd0,  5'd0,  1'b0, 1'b1};
        tbl[2] = '{32'h55555555, 6'd32, 5'd0,  1'b1, 1'b0};
        tbl[3] = '{32'hAAAAAABA, 6'd1,  5'd4,  1'b1, 1'b0};
        tbl[4] = '{32'h2AAAAAAA, 6'd1,  5'd31, 1'b1, 1'b0};

        rst_n = 1'b0;
        #12;
        chk("reset_outputs_u0", outs0(), 64'h0);
        chk("reset_busy_u1", {63'h0, u1.busy}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // abort beats a simultaneous start in IDLE
        u0.start = 1'b1; u0.abort = 1'b1;
        tick();
        chk("idle_abort_wins_busy", {63'h0, u0.busy}, 64'h0);
        chk("idle_abort_no_pulse", {63'h0, u0.aborted}, 64'h0);
        u0.start = 1'b0; u0.abort = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) begin
            scan0(tbl[k].exp_tt, lat, ok);
            chk($sformatf("tbl%0d_latency", k), 64'(lat), 64'd32);
            chk($sformatf("tbl%0d_vec_steps", k), {63'h0, ok}, 64'h1);
            chk($sformatf("tbl%0d_busy_low", k), {63'h0, u0.busy}, 64'h0);
            chk($sformatf("tbl%0d_tt", k), 64'(u0.tt_out), 64'hAAAAAAAA);
            chk($sformatf("tbl%0d_mcnt", k), 64'(u0.mismatch_cnt), 64'(tbl[k].mcnt));
            chk($sformatf("tbl%0d_ffidx", k), 64'(u0.first_fail_idx), 64'(tbl[k].ffidx));
            chk($sformatf("tbl%0d_ffvalid", k), {63'h0, u0.first_fail_valid}, 64'(tbl[k].ffvalid));
            chk($sformatf("tbl%0d_pass", k), {63'h0, u0.pass}, 64'(tbl[k].pass));
            tick();
            chk($sformatf("tbl%0d_done_one_cycle", k), {63'h0, u0.done}, 64'h0);
        end

        // abort while vec_out = 10
        u0.exp_tt = 32'hAAAA8A8B;
        u0.start  = 1'b1;
        tick();
        u0.start  = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("abort_pre_vec", 64'(u0.vec_out), 64'd10);
        u0.abort = 1'b1;
        tick();
        u0.abort = 1'b0;
        chk("abort_busy", {63'h0, u0.busy}, 64'h0);
        chk("abort_pulse", {63'h0, u0.aborted}, 64'h1);
        chk("abort_vec", 64'(u0.vec_out), 64'h0);
        chk("abort_tt_partial", 64'(u0.tt_out), 64'h2AA);
        chk("abort_mcnt_partial", 64'(u0.mismatch_cnt), 64'd2);
        chk("abort_ffvalid", {63'h0, u0.first_fail_valid}, 64'h1);
        ok = 1'b1;
        tick();
        chk("abort_pulse_drop", {63'h0, u0.aborted}, 64'h0);
        for (int k = 0; k < 40; k++) begin
            if (u0.done !== 1'b0 || u0.busy !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("abort_no_done", {63'h0, ok}, 64'h1);

        // start held high: back-to-back scans, toggles mid-scan ignored
        u0.exp_tt = 32'hAAAAAAAA;
        u0.start  = 1'b1;
        tick();
        ok = (u0.busy === 1'b1) && (u0.vec_out === 5'd0);
        for (int k = 1; k <= 32; k++) begin
            if (k >= 5 && k <= 8) u0.start = ~u0.start;
            tick();
            if (k < 32 && u0.vec_out !== 5'(k)) ok = 1'b0;
            if (k == 9) u0.start = 1'b1;
        end
        chk("b2b_first_steps", {63'h0, ok}, 64'h1);
        chk("b2b_first_done", {63'h0, u0.done}, 64'h1);
        tick();
        chk("b2b_idle_gap", {62'h0, u0.busy, u0.done}, 64'h0);
        tick();
        chk("b2b_restart", {62'h0, u0.busy, u0.vec_out == 5'd0}, 64'h3);
        chk("b2b_restart_clear", {63'h0, u0.pass}, 64'h0);
        for (int k = 0; k < 32; k++) tick();
        chk("b2b_second_done", {63'h0, u0.done}, 64'h1);
        chk("b2b_second_pass", {63'h0, u0.pass}, 64'h1);
        u0.start = 1'b0;
        tick();
        tick();

        // SETTLE=3 with a delayed datapath
        for (int i = 0; i < 32; i++) exp1[i] = f5(5'(i));
        u1.exp_tt = exp1;
        u1.start  = 1'b1;
        tick();
        u1.start  = 1'b0;
        ok  = (u1.vec_out === 5'd0);
        lat = 0;
        while (u1.done !== 1'b1 && lat < 400) begin
            tick();
            lat++;
            if (u1.done !== 1'b1 && u1.vec_out !== 5'(lat / 3)) ok = 1'b0;
        end
        chk("s3_latency", 64'(lat), 64'd96);
        chk("s3_hold3", {63'h0, ok}, 64'h1);
        chk("s3_tt", 64'(u1.tt_out), 64'(exp1));
        chk("s3_mcnt", 64'(u1.mismatch_cnt), 64'h0);
        chk("s3_pass", {63'h0, u1.pass}, 64'h1);
        tick();

        // asynchronous reset mid-scan at vector 12
        u0.exp_tt = 32'hAAAA8A8B;
        u0.start  = 1'b1;
        tick();
        u0.start  = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("rst_pre_vec", 64'(u0.vec_out), 64'd12);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", outs0(), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        u0.start = 1'b1;
        tick();
        u0.start = 1'b0;
        chk("rst_then_start", {62'h0, u0.busy, u0.vec_out == 5'd0}, 64'h3);
        tick();
        chk("rst_then_step", 64'(u0.vec_out), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
